// File: rtl/int2float_pipe.sv
// Two-stage unsigned integer to small float converter with valid/ready handshake.
// Define INT2FLOAT_RNE_EN for round-to-nearest-even with saturation; default truncates.
module int2float_pipe #(
    parameter int unsigned IN_W  = 11,
    parameter int unsigned EXP_W = 3,
    parameter int unsigned MAN_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W-1:0] out_data,
    output logic                   out_ovf
);

    localparam int MaxExp = (1 << EXP_W) - 1;
    localparam int PW     = $clog2(IN_W + 1);
    localparam int OW     = EXP_W + MAN_W;

    if ((int'(IN_W) - int'(MAN_W) > MaxExp) || (MAN_W < 1)) begin : g_param_err
        $error("int2float_pipe: exponent field too narrow for IN_W/MAN_W, or MAN_W < 1");
    end

    logic             s1_valid_q;
    logic [IN_W-1:0]  s1_data_q;
    logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
    logic [PW-1:0]    lead;

    logic             out_valid_q;
    logic [OW-1:0]    out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;

    logic             s1_load, s2_load;

    assign s2_load  = !out_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    // Stage 1: leading-one index and biased exponent (0 for the denormal range).
    always_comb begin
        lead = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (in_data[i]) lead = PW'(i);
        end
        s1_exp_d = '0;
        if ((in_data >> MAN_W) != '0) s1_exp_d = EXP_W'(int'(lead) - int'(MAN_W) + 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_exp_q   <= '0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_data_q <= in_data;
                s1_exp_q  <= s1_exp_d;
            end
        end
    end

    // Stage 2: mantissa sits at bit (exp-1) upward; bits below it are discarded.
    logic [EXP_W-1:0] sh;
    logic [IN_W-1:0]  shifted;
    logic [MAN_W-1:0] man_trunc;
`ifdef INT2FLOAT_RNE_EN
    logic [IN_W-1:0]  rem_mask, rem, half;
    logic             round_up, carry;
    logic [MAN_W-1:0] man_rnd;
    logic [EXP_W:0]   exp_rnd;
`endif

    always_comb begin
        sh        = (s1_exp_q == '0) ? '0 : s1_exp_q - 1'b1;
        shifted   = s1_data_q >> sh;
        man_trunc = MAN_W'(shifted);
`ifdef INT2FLOAT_RNE_EN
        rem_mask  = (IN_W'(1) << sh) - IN_W'(1);
        rem       = s1_data_q & rem_mask;
        half      = (sh == '0) ? '0 : (IN_W'(1) << (sh - 1'b1));
        round_up  = (sh != '0) && ((rem > half) || ((rem == half) && man_trunc[0]));
        {carry, man_rnd} = {1'b0, man_trunc} + {{MAN_W{1'b0}}, round_up};
        exp_rnd   = {1'b0, s1_exp_q} + {{EXP_W{1'b0}}, carry};
        if (exp_rnd[EXP_W]) begin
            out_data_d = '1;
            out_ovf_d  = 1'b1;
        end else begin
            out_data_d = {exp_rnd[EXP_W-1:0], man_rnd};
            out_ovf_d  = 1'b0;
        end
`else
        out_data_d = {s1_exp_q, man_trunc};
        out_ovf_d  = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q <= out_data_d;
                out_ovf_q  <= out_ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_int2float_pipe.sv
// Scoreboard bench for int2float_pipe: vector table, stream, backpressure and mid-flight reset.
// Expectations follow INT2FLOAT_RNE_EN the same way the design does.
module tb_int2float_pipe;

    localparam int IN_W  = 11;
    localparam int EXP_W = 3;
    localparam int MAN_W = 4;
    localparam int OW    = EXP_W + MAN_W;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [IN_W-1:0] in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [OW-1:0]   out_data;
    logic            out_ovf;

    always #5 clk = ~clk;

    int2float_pipe #(
        .IN_W (IN_W),
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf)
    );

    typedef struct {
        logic [OW-1:0] d;
        logic          ovf;
        int            acc;
    } exp_t;

    typedef struct {
        int            v;
        logic [OW-1:0] d;
        logic          ovf;
    } vec_t;

    exp_t          sb[$];
    vec_t          tbl[14];
    int            n_cmp = 0, n_bad = 0, cyc = 0;
    int            n_acc = 0, n_drn = 0, n_unexp = 0;
    bit            chk_lat = 1'b1;
    bit            stall_prev = 1'b0;
    logic [OW-1:0] nxt_d, held_d;
    logic          nxt_ovf, held_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Independent reference: find the octave by magnitude, then round the quotient.
    function automatic logic [OW:0] model(input int v);
        int e, q;
`ifdef INT2FLOAT_RNE_EN
        int r, ulp;
`endif
        if (v < (1 << MAN_W)) return {1'b0, OW'(v)};
        e = 1;
        while (v >= (1 << (e + MAN_W))) e++;
        q = v >> (e - 1);
`ifdef INT2FLOAT_RNE_EN
        r   = v - (q << (e - 1));
        ulp = 1 << (e - 1);
        if ((2 * r > ulp) || ((2 * r == ulp) && (q % 2 == 1))) q++;
        if (q == (2 << MAN_W)) begin
            q = 1 << MAN_W;
            e++;
        end
        if (e > (1 << EXP_W) - 1) return {1'b1, {OW{1'b1}}};
`endif
        return {1'b0, EXP_W'(e), MAN_W'(q)};
    endfunction

    // One clock: score the handshakes that will happen at the coming edge, then advance.
    task automatic step();
        exp_t e;
        if (stall_prev) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data", {24'h0, out_ovf, out_data}, {24'h0, held_ovf, held_d});
        end
        if (out_valid && out_ready) begin
            n_drn++;
            if (sb.size() == 0) begin
                n_unexp++;
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got %0h, expected no output (cycle %0d)",
                         out_data, cyc);
            end else begin
                e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e.d));
                check("out_ovf", 32'(out_ovf), 32'(e.ovf));
                if (chk_lat) check("latency", 32'(cyc - e.acc), 2);
            end
        end
        stall_prev = out_valid && !out_ready;
        held_d     = out_data;
        held_ovf   = out_ovf;
        if (in_valid && in_ready) begin
            n_acc++;
            e.d   = nxt_d;
            e.ovf = nxt_ovf;
            e.acc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic offer(input int v);
        in_valid = 1'b1;
        in_data  = IN_W'(v);
        {nxt_ovf, nxt_d} = model(v);
    endtask

    task automatic wait_drain(input int bound);
        int k = 0;
        while (sb.size() != 0 && k < bound) begin
            step();
            k++;
        end
        check("drain_empty", 32'(sb.size()), 0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, idx, k;
        int vals[3];

        tbl[0] = '{0,    7'h00, 1'b0};
        tbl[1] = '{1,    7'h01, 1'b0};
        tbl[2] = '{13,   7'h0D, 1'b0};
        tbl[3] = '{15,   7'h0F, 1'b0};
        tbl[4] = '{16,   7'h10, 1'b0};
        tbl[5] = '{31,   7'h1F, 1'b0};
        tbl[6] = '{1000, 7'h6F, 1'b0};
        tbl[7] = '{1024, 7'h70, 1'b0};
        tbl[8] = '{37,   7'h22, 1'b0};
        tbl[9] = '{1048, 7'h70, 1'b0};
`ifdef INT2FLOAT_RNE_EN
        tbl[10] = '{39,   7'h24, 1'b0};
        tbl[11] = '{2047, 7'h7F, 1'b1};
        tbl[12] = '{63,   7'h30, 1'b0};
        tbl[13] = '{47,   7'h28, 1'b0};
`else
        tbl[10] = '{39,   7'h23, 1'b0};
        tbl[11] = '{2047, 7'h7F, 1'b0};
        tbl[12] = '{63,   7'h2F, 1'b0};
        tbl[13] = '{47,   7'h27, 1'b0};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_ovf", 32'(out_ovf), 0);
        rst_n = 1'b1;
        check("post_rst_in_ready", 32'(in_ready), 1);
        out_ready = 1'b1;

        // Vector table, one transfer at a time
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            in_data  = IN_W'(tbl[i].v);
            nxt_d    = tbl[i].d;
            nxt_ovf  = tbl[i].ovf;
            step();
            in_valid = 1'b0;
            wait_drain(8);
        end

        // Back-to-back stream 1..20
        base = n_drn;
        for (int i = 1; i <= 20; i++) begin
            offer(i);
            check("stream_in_ready", 32'(in_ready), 1);
            step();
        end
        in_valid = 1'b0;
        wait_drain(10);
        check("stream_count", 32'(n_drn - base), 20);

        // Backpressure: 3 offered over 5 stalled cycles
        chk_lat   = 1'b0;
        out_ready = 1'b0;
        vals      = '{100, 200, 300};
        base      = n_acc;
        for (int c = 0; c < 5; c++) begin
            idx = (n_acc - base < 3) ? n_acc - base : 2;
            offer(vals[idx]);
            step();
        end
        check("bp_accepted", 32'(n_acc - base), 2);
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_out_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        k = 0;
        while (n_acc - base < 3 && k < 10) begin
            idx = (n_acc - base < 3) ? n_acc - base : 2;
            offer(vals[idx]);
            step();
            k++;
        end
        in_valid = 1'b0;
        wait_drain(10);
        check("bp_total_accepted", 32'(n_acc - base), 3);
        chk_lat = 1'b1;

        // Reset with both stages full
        out_ready = 1'b0;
        offer(500);
        step();
        offer(600);
        step();
        in_valid = 1'b0;
        check("full_out_valid", 32'(out_valid), 1);
        check("full_in_ready", 32'(in_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 0);
        check("async_rst_out_data", 32'(out_data), 0);
        sb.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_release_in_ready", 32'(in_ready), 1);
        out_ready = 1'b1;
        base = n_unexp;
        repeat (6) step();
        check("no_stale_output", 32'(n_unexp - base), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
